// File: rtl/lfsr_pkg.sv
// Purpose: shared constants and helpers for the Fibonacci LFSR symbol source.
// Latency: none (package; constants and pure functions only).
// Backpressure: none.
package lfsr_pkg;

  // Signed 1s17 levels of the 4-level symbol alphabet (+/-0.25, +/-0.75).
  localparam logic [17:0] SYM_M3 = 18'h28000;  // -0.75
  localparam logic [17:0] SYM_M1 = 18'h38000;  // -0.25
  localparam logic [17:0] SYM_P1 = 18'h08000;  // +0.25
  localparam logic [17:0] SYM_P3 = 18'h18000;  // +0.75

  // Only these lengths have a known two-tap maximal-length polynomial here.
  function automatic bit width_supported(input int width);
    case (width)
      7, 15, 22, 23, 31: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

  // Second feedback tap (1-based) for each supported length; the first tap
  // is always the MSB. Unsupported widths return 1 only so that indexing
  // stays legal while the elaboration check reports the real problem.
  function automatic int tap_of(input int width);
    case (width)
      7:       return 6;
      15:      return 14;
      22:      return 21;
      23:      return 18;
      31:      return 28;
      default: return 1;
    endcase
  endfunction

  // Gray mapping: adjacent levels differ in exactly one bit.
  function automatic logic [17:0] pam4_map(input logic [1:0] bits);
    case (bits)
      2'b00:   return SYM_M3;
      2'b01:   return SYM_M1;
      2'b11:   return SYM_P1;
      default: return SYM_P3;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_prbs_gen_sps_divider.sv
// Purpose: samples-per-symbol divider; counts en cycles 0..SPS-1.
// Latency: tc is combinational on the current count and en.
// Backpressure: en low freezes the count; clr forces it back to 0.
// Ports: clk, reset (sync, active-high), en (advance), clr (restart symbol),
//        tc (high on the en cycle that completes a symbol).
module sps_divider
  import lfsr_pkg::*;
#(
  parameter int SPS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);

  logic [CW-1:0] div_cnt;

  assign tc = en && (div_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      div_cnt <= '0;
    end else if (tc) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Purpose: parametrised Fibonacci LFSR driving a Gray-coded 4-level 1s17
//          symbol, with seed load, wrap detection and period measurement.
// Latency: one clock from the step cycle (or load) to updated outputs.
// Backpressure: en low holds the divider and LFSR; load acts regardless of en.
// Ports: clk, reset (sync, active-high), en, load, seed_in -> state, sym_out,
//        sym_stb, wrap, period_len, lockup (all registered).
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 22,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter int               SPS   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic [17:0]      sym_out,
  output logic             sym_stb,
  output logic             wrap,
  output logic [WIDTH-1:0] period_len,
  output logic             lockup
);

  localparam int T = tap_of(WIDTH);

  if (!width_supported(WIDTH)) begin : g_bad_width
    $error("lfsr_prbs_gen: unsupported WIDTH %0d", WIDTH);
  end
  if (SPS < 1) begin : g_bad_sps
    $error("lfsr_prbs_gen: SPS must be at least 1");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_prbs_gen: SEED must be nonzero");
  end

  logic             step;
  logic [WIDTH-1:0] state_nxt;
  logic [WIDTH-1:0] seed_act;   // seed the current period is measured against
  logic [WIDTH-1:0] step_cnt;   // steps since the last seed hit
  logic [WIDTH-1:0] load_val;
  logic             load_zero;

  // A load restarts the symbol, so it also restarts the divider.
  sps_divider #(
    .SPS (SPS)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tc    (step)
  );

  assign state_nxt = {state[WIDTH-2:0], state[WIDTH-1] ^ state[T-1]};

  // A zero seed would lock the LFSR at zero forever; fall back to SEED.
  assign load_zero = (seed_in == '0);
  assign load_val  = load_zero ? SEED : seed_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEED;
      seed_act   <= SEED;
      sym_out    <= pam4_map(SEED[1:0]);
      sym_stb    <= 1'b0;
      wrap       <= 1'b0;
      lockup     <= 1'b0;
      period_len <= '0;
      step_cnt   <= '0;
    end else begin
      sym_stb <= 1'b0;
      wrap    <= 1'b0;
      lockup  <= 1'b0;
      if (load) begin
        state    <= load_val;
        seed_act <= load_val;
        sym_out  <= pam4_map(load_val[1:0]);
        lockup   <= load_zero;
        step_cnt <= '0;
      end else if (step) begin
        state   <= state_nxt;
        sym_out <= pam4_map(state_nxt[1:0]);
        sym_stb <= 1'b1;
        // step_cnt+1 never exceeds 2^WIDTH-1, so the period always fits.
        if (state_nxt == seed_act) begin
          wrap       <= 1'b1;
          period_len <= step_cnt + WIDTH'(1);
          step_cnt   <= '0;
        end else begin
          step_cnt <= step_cnt + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
module tb_lfsr_prbs_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WIDTH=22, SPS=4, default seed
  logic        rst_a, en_a, ld_a;
  logic [21:0] sd_a, st_a, pl_a;
  logic [17:0] sym_a;
  logic        stb_a, wrap_a, lock_a;

  // DUT B: WIDTH=7, SPS=1, default seed
  logic        rst_b, en_b, ld_b;
  logic [6:0]  sd_b, st_b, pl_b;
  logic [17:0] sym_b;
  logic        stb_b, wrap_b, lock_b;

  lfsr_prbs_gen #(.WIDTH(22), .SEED(22'h3FFFFF), .SPS(4)) dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .load(ld_a), .seed_in(sd_a),
    .state(st_a), .sym_out(sym_a), .sym_stb(stb_a), .wrap(wrap_a),
    .period_len(pl_a), .lockup(lock_a)
  );

  lfsr_prbs_gen #(.WIDTH(7), .SEED(7'h7F), .SPS(1)) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .load(ld_b), .seed_in(sd_b),
    .state(st_b), .sym_out(sym_b), .sym_stb(stb_b), .wrap(wrap_b),
    .period_len(pl_b), .lockup(lock_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift left, new LSB = parity of the two tapped bits (MSB and tap t).
  function automatic logic [31:0] ref_next(input logic [31:0] s, input int w, input int t);
    logic [31:0] mask;
    int          fb;
    mask = (32'd1 << (w - 1)) | (32'd1 << (t - 1));
    fb   = $countones(s & mask) % 2;
    return ((s << 1) | 32'(fb)) & ((32'd1 << w) - 32'd1);
  endfunction

  // Gray code -> index 0..3 -> level 2*idx-3 in quarter units; 0.25 = 2^15.
  function automatic logic [17:0] ref_sym(input logic [1:0] g);
    int idx;
    idx = (g[1] ? 2 : 0) + ((g[1] ^ g[0]) ? 1 : 0);
    return 18'((2 * idx - 3) * 32768);
  endfunction

  // Reference model state
  logic [31:0] m_a, ms_a, m_b;
  int dv_a, ct_a, pr_a, ct_b, pr_b;
  logic e_stb_a, e_wrap_a, e_lock_a, e_stb_b, e_wrap_b;

  task automatic tick();
    @(posedge clk);
    e_stb_a = 0; e_wrap_a = 0; e_lock_a = 0;
    if (rst_a) begin
      m_a = 32'h3FFFFF; ms_a = m_a; dv_a = 0; ct_a = 0; pr_a = 0;
    end else if (ld_a) begin
      m_a = (sd_a == 0) ? 32'h3FFFFF : 32'(sd_a);
      ms_a = m_a; e_lock_a = (sd_a == 0); dv_a = 0; ct_a = 0;
    end else if (en_a) begin
      dv_a++;
      if (dv_a == 4) begin
        dv_a = 0; m_a = ref_next(m_a, 22, 21); e_stb_a = 1; ct_a++;
        if (m_a == ms_a) begin e_wrap_a = 1; pr_a = ct_a; ct_a = 0; end
      end
    end
    e_stb_b = 0; e_wrap_b = 0;
    if (rst_b) begin
      m_b = 32'h7F; ct_b = 0; pr_b = 0;
    end else if (en_b) begin
      m_b = ref_next(m_b, 7, 6); e_stb_b = 1; ct_b++;
      if (m_b == 32'h7F) begin e_wrap_b = 1; pr_b = ct_b; ct_b = 0; end
    end
    #1;
    cyc++;
    chk("a_state",  32'(st_a),   m_a);
    chk("a_sym",    32'(sym_a),  32'(ref_sym(m_a[1:0])));
    chk("a_stb",    32'(stb_a),  32'(e_stb_a));
    chk("a_wrap",   32'(wrap_a), 32'(e_wrap_a));
    chk("a_lockup", 32'(lock_a), 32'(e_lock_a));
    chk("a_period", 32'(pl_a),   32'(pr_a));
    chk("b_state",  32'(st_b),   m_b);
    chk("b_sym",    32'(sym_b),  32'(ref_sym(m_b[1:0])));
    chk("b_stb",    32'(stb_b),  32'(e_stb_b));
    chk("b_wrap",   32'(wrap_b), 32'(e_wrap_b));
    chk("b_period", 32'(pl_b),   32'(pr_b));
    chk("b_lockup", 32'(lock_b), 32'd0);
  endtask

  initial begin
    int c0, n, r;
    logic [31:0] s0;
    logic found, saw_zero, stb_gap;

    rst_a = 1; rst_b = 1; en_a = 0; en_b = 0; ld_a = 0; ld_b = 0;
    sd_a = '0; sd_b = '0;
    tick(); tick();
    chk("rst_state", 32'(st_a), 32'h3FFFFF);
    chk("rst_sym", 32'(sym_a), 32'h08000);
    chk("rst_period", 32'(pl_a), 32'd0);

    // First step after four enabled clocks
    rst_a = 0; en_a = 1;
    repeat (3) tick();
    chk("pre_step_stb", 32'(stb_a), 32'd0);
    tick();
    chk("step1_state", 32'(st_a), 32'h3FFFFE);
    chk("step1_sym", 32'(sym_a), 32'h18000);
    chk("step1_stb", 32'(stb_a), 32'd1);
    tick();
    chk("step1_stb_one_clk", 32'(stb_a), 32'd0);

    // en low for two clocks mid-symbol stretches that symbol to 6 clocks
    found = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (stb_a) begin found = 1; break; end end
    chk("stall_find_stb", 32'(found), 32'd1);
    c0 = cyc; s0 = 32'(st_a);
    tick();
    en_a = 0; tick(); tick();
    en_a = 1;
    found = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (stb_a) begin found = 1; break; end end
    chk("stall_found", 32'(found), 32'd1);
    chk("stall_spacing", 32'(cyc - c0), 32'd6);
    chk("stall_one_step", 32'(st_a), ref_next(s0, 22, 21));

    // Load seed 1 mid-symbol
    tick(); tick();
    ld_a = 1; sd_a = 22'h000001;
    tick();
    ld_a = 0;
    chk("load1_state", 32'(st_a), 32'h1);
    chk("load1_sym", 32'(sym_a), 32'h38000);
    chk("load1_no_stb", 32'(stb_a), 32'd0);
    repeat (3) tick();
    chk("load1_hold", 32'(st_a), 32'h1);
    tick();
    chk("load1_step", 32'(st_a), 32'h2);
    chk("load1_step_stb", 32'(stb_a), 32'd1);

    // Zero-seed load falls back to SEED with a lockup pulse
    ld_a = 1; sd_a = '0;
    tick();
    ld_a = 0;
    chk("zload_lockup", 32'(lock_a), 32'd1);
    chk("zload_state", 32'(st_a), 32'h3FFFFF);
    tick();
    chk("zload_lockup_one_clk", 32'(lock_a), 32'd0);

    // Load on a step cycle: divider is at its last count after 3 more clocks
    tick(); tick();
    ld_a = 1; sd_a = 22'h012345;
    tick();
    ld_a = 0;
    chk("ldstep_state", 32'(st_a), 32'h012345);
    chk("ldstep_no_stb", 32'(stb_a), 32'd0);

    // Randomised en / load / reset traffic against the model
    for (int i = 0; i < 400; i++) begin
      en_a = ($urandom_range(9, 0) < 7);
      r = $urandom_range(59, 0);
      ld_a = (r < 3);
      sd_a = (r == 0) ? 22'h0 : 22'($urandom);
      rst_a = (r == 3);
      tick();
    end
    rst_a = 0; ld_a = 0; en_a = 0;

    // WIDTH=7, SPS=1: wrap every 127 clocks, strobe continuous, never zero
    rst_b = 0; en_b = 1;
    saw_zero = 0; stb_gap = 0;
    for (int w = 0; w < 2; w++) begin
      n = 0; found = 0;
      for (int i = 0; i < 200; i++) begin
        tick(); n++;
        if (st_b == 0) saw_zero = 1;
        if (!stb_b) stb_gap = 1;
        if (wrap_b) begin found = 1; break; end
      end
      chk("b_wrap_found", 32'(found), 32'd1);
      chk("b_wrap_steps", 32'(n), 32'd127);
      chk("b_period_len", 32'(pl_b), 32'd127);
    end
    chk("b_never_zero", 32'(saw_zero), 32'd0);
    chk("b_stb_continuous", 32'(stb_gap), 32'd0);

    // Reset on the cycle that would otherwise wrap
    repeat (126) tick();
    rst_b = 1;
    tick();
    chk("b_rst_no_wrap", 32'(wrap_b), 32'd0);
    chk("b_rst_period", 32'(pl_b), 32'd0);
    chk("b_rst_state", 32'(st_b), 32'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
